ula_muldiv: RTL and testbench
=============================

// Module: ula_muldiv
// PURPOSE
//   Next-generation MIPS execute unit. Keeps the single-cycle combinational ALU,
//   now WIDTH-parametrised, and adds an iterative multiply/divide sequencer with
//   architectural HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//   Sits in EX, fed by ula_ctrl. The pipeline stalls while busy=1.
//   MFHI/MFLO read the hi/lo ports directly.
// PARAMETERS
//   WIDTH  32  datapath width; must be >= 8
//   SHW    $clog2(WIDTH), localparam  shift-amount width
// PORTS
//   clk        in   1      clock; all state updates on the rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   In1        in   WIDTH  operand 1 (rs; shamt for shifts); dividend/multiplicand
//   In2        in   WIDTH  operand 2 (rt); divisor/multiplier
//   OP         in   4      ALU op code: ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOR=5 SLT=6 SLTU=7
//                          SLL=8 SRL=9 SRA=10 SLLV=11 SRLV=12 SRAV=13 JR=14
//   result     out  WIDTH  combinational ALU result
//   Zero_Flag  out  1      result == 0
//   md_start   in   1      launch md_op; sampled only when busy=0
//   md_op      in   3      MULT=0 MULTU=1 DIV=2 DIVU=3 MTHI=4 MTLO=5; 6-7 are no-ops
//   md_flush   in   1      abort the in-flight mul/div
//   busy       out  1      sequencer is iterating
//   done       out  1      one-cycle pulse; HI/LO were updated this cycle
//   div_zero   out  1      pulses with done when a DIV/DIVU had In2 == 0
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
// BEHAVIOUR
//   ALU path: purely combinational, unchanged semantics.
//   - Shifts use In1[SHW-1:0] as the amount. SRA/SRAV shift arithmetically.
//   - SLT compares signed, SLTU compares unsigned; result is 1 or 0.
//   - JR passes In1 through. Undefined OP gives 0.
//   Reset (async, rst_n=0): state=IDLE; hi, lo, busy, done, div_zero = 0.
//     Any in-flight operation is discarded.
//   FSM states: IDLE -> CALC -> FIN -> IDLE.
//   - IDLE & md_start & md_op in {0..3}: latch operands, count=0, go to CALC.
//     * Signed ops latch |In1| and |In2| plus sign flags.
//     * busy=1 from the next cycle.
//   - IDLE & md_start & MTHI/MTLO: hi<=In1 / lo<=In1 at that edge.
//     * Stays in IDLE; busy and done are not asserted.
//   - CALC: one iteration per clock for WIDTH clocks.
//     * Multiply: shift-add, 2*WIDTH-bit product.
//     * Divide: restoring, one quotient bit per clock.
//     * After the WIDTH-th iteration, go to FIN.
//   - FIN: apply sign correction, write hi/lo, done=1 and busy=0 for one cycle.
//     * Returns to IDLE.
//   Latency: done is high WIDTH+1 clocks after the md_start edge; 33 for WIDTH=32.
//     A new md_start is accepted in the done cycle.
//   Results:
//   - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
//   - DIV/DIVU: lo = quotient, hi = remainder.
//   - Signed divide truncates toward zero; the remainder takes the dividend's sign.
//   Boundary cases:
//   - Divide by zero: hi=In1, lo=all ones, div_zero=1 with done.
//     The full WIDTH-cycle latency still applies.
//   - Signed MIN / -1: lo=MIN, hi=0, no flag.
//   - md_start while busy=1: ignored; the operation in flight is unaffected.
//   - md_flush while busy=1: next edge state=IDLE, busy=0, no done, hi/lo unchanged.
//     md_flush in IDLE has no effect.
//   - md_flush and md_start in the same IDLE cycle: the start wins.
//   - Operand inputs may change after the start edge; results use the latched values.
// TESTING
//   1 ALU: OP=SUB, 5,5 -> result=0, Zero_Flag=1.
//     OP=SRA, In1=4, In2=0x80000000 -> 0xF8000000.
//     OP=SLTU, 1 vs 0xFFFFFFFF -> 1.
//   2 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 33 clks after start.
//     MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=0x00000001.
//   3 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 7/2 -> lo=3, hi=1.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4 DIV 9/0 -> done with div_zero=1, hi=9, lo=0xFFFFFFFF.
//     MTHI In1=0x1234 -> hi=0x1234 next cycle, busy stays 0.
//   5 md_start pulsed mid-MULT -> ignored, original product returned.
//     md_flush at clock 10 -> busy=0 next cycle, no done, hi/lo keep prior values.
//   6 rst_n low mid-DIV -> hi=lo=0, busy=done=0 immediately, without a clock edge.
//     A fresh MULT after release completes normally.

Source files
------------

// File: rtl/ula_muldiv.sv
// rtl/ula_muldiv.sv - MIPS execute unit: combinational ALU plus iterative mul/div sequencer with HI/LO
module ula_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [3:0]       OP,
   output logic [WIDTH-1:0] result,
   output logic             Zero_Flag,
   input  logic             md_start,
   input  logic [2:0]       md_op,
   input  logic             md_flush,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   logic [SHW-1:0] shamt;
   assign shamt = In1[SHW-1:0];

   always_comb begin
      result = '0;
      case (OP)
         4'd0:         result = In1 + In2;
         4'd1:         result = In1 - In2;
         4'd2:         result = In1 & In2;
         4'd3:         result = In1 | In2;
         4'd4:         result = In1 ^ In2;
         4'd5:         result = ~(In1 | In2);
         4'd6:         result = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
         4'd7:         result = {{(WIDTH-1){1'b0}}, (In1 < In2)};
         4'd8, 4'd11:  result = In2 << shamt;
         4'd9, 4'd12:  result = In2 >> shamt;
         4'd10, 4'd13: result = $signed(In2) >>> shamt;
         4'd14:        result = In1;
         default:      result = '0;
      endcase
   end

   assign Zero_Flag = (result == '0);

   state_t         st_q;
   logic [SHW-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q, q_q, m_q, hi_q, lo_q;
   logic is_div_q, neg_q_q, neg_r_q, dz_q, busy_q, done_q, dzo_q;

   logic             sgn_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;

   // Signed ops run on magnitudes; signs are restored in FIN.
   assign sgn_op = (md_op == 3'd0) || (md_op == 3'd2);
   assign a_neg  = sgn_op & In1[WIDTH-1];
   assign b_neg  = sgn_op & In2[WIDTH-1];
   assign a_abs  = a_neg ? -In1 : In1;
   assign b_abs  = b_neg ? -In2 : In2;

   logic [WIDTH:0]   mul_sum, div_shift;
   logic [WIDTH-1:0] div_diff, acc_d, q_d;
   logic             div_ge;

   // Multiply: {acc,q} shifts right, multiplier in q. Divide: {acc,q} shifts left, quotient bits enter q.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};
      div_shift = {acc_q, q_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, m_q});
      div_diff  = div_shift[WIDTH-1:0] - m_q;
      if (is_div_q) begin
         acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
         q_d   = {q_q[WIDTH-2:0], div_ge};
      end else begin
         acc_d = mul_sum[WIDTH:1];
         q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, hi_d, lo_d;

   // A zero divisor leaves the dividend magnitude in acc, so rem_fix recreates the original In1.
   always_comb begin
      prod     = {acc_q, q_q};
      prod_fix = neg_q_q ? -prod : prod;
      quo_fix  = neg_q_q ? -q_q : q_q;
      rem_fix  = neg_r_q ? -acc_q : acc_q;
      if (!is_div_q) begin
         {hi_d, lo_d} = prod_fix;
      end else if (dz_q) begin
         hi_d = rem_fix;
         lo_d = '1;
      end else begin
         hi_d = rem_fix;
         lo_d = quo_fix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q     <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         q_q      <= '0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dzo_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dzo_q  <= 1'b0;
         case (st_q)
            S_IDLE: begin
               if (md_start) begin
                  if (md_op < 3'd4) begin
                     st_q     <= S_CALC;
                     busy_q   <= 1'b1;
                     cnt_q    <= '0;
                     acc_q    <= '0;
                     is_div_q <= md_op[1];
                     neg_q_q  <= a_neg ^ b_neg;
                     neg_r_q  <= a_neg;
                     dz_q     <= md_op[1] && (In2 == '0);
                     q_q      <= md_op[1] ? a_abs : b_abs;
                     m_q      <= md_op[1] ? b_abs : a_abs;
                  end else if (md_op == 3'd4) begin
                     hi_q <= In1;
                  end else if (md_op == 3'd5) begin
                     lo_q <= In1;
                  end
               end
            end
            S_CALC: begin
               if (md_flush) begin
                  st_q   <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  q_q   <= q_d;
                  cnt_q <= cnt_q + SHW'(1);
                  if (cnt_q == LAST) st_q <= S_FIN;
               end
            end
            S_FIN: begin
               st_q   <= S_IDLE;
               busy_q <= 1'b0;
               if (!md_flush) begin
                  hi_q   <= hi_d;
                  lo_q   <= lo_d;
                  done_q <= 1'b1;
                  dzo_q  <= dz_q;
               end
            end
            default: begin
               st_q   <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dzo_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
endmodule

// File: tb/tb_ula_muldiv.sv
// tb/tb_ula_muldiv.sv - self-checking bench for ula_muldiv against an arithmetic reference model
module tb_ula_muldiv;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  In1, In2, result, hi, lo;
   logic [3:0]    OP;
   logic          Zero_Flag, md_start, md_flush, busy, done, div_zero;
   logic [2:0]    md_op;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_hi, exp_lo;

   ula_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .In1(In1), .In2(In2), .OP(OP),
      .result(result), .Zero_Flag(Zero_Flag), .md_start(md_start), .md_op(md_op),
      .md_flush(md_flush), .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned sh;
      int          sa, sb;
      sh = a % W;
      sa = a;
      sb = b;
      case (op)
         4'd0:         return a + b;
         4'd1:         return a - b;
         4'd2:         return a & b;
         4'd3:         return a | b;
         4'd4:         return a ^ b;
         4'd5:         return ~(a | b);
         4'd6:         return (sa < sb) ? 1 : 0;
         4'd7:         return (a < b) ? 1 : 0;
         4'd8, 4'd11:  return b << sh;
         4'd9, 4'd12:  return b >> sh;
         4'd10, 4'd13: return sb >>> sh;
         4'd14:        return a;
         default:      return 0;
      endcase
   endfunction

   task automatic md_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      sa = a;
      sb = b;
      dz = 1'b0;
      h  = 0;
      l  = 0;
      case (op)
         3'd0: begin sp = longint'(sa) * longint'(sb); {h, l} = sp; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
         3'd2: begin
            if (b == 0) begin h = a; l = '1; dz = 1'b1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = a; end
            else begin l = sa / sb; h = sa % sb; end
         end
         3'd3: begin
            if (b == 0) begin h = a; l = '1; dz = 1'b1; end
            else begin l = a / b; h = a % b; end
         end
         default: ;
      endcase
   endtask

   // mode: 0 plain, 1 stray md_start mid-op, 2 flush at clock 10, 3 flush together with start
   task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int mode);
      logic [W-1:0] h, l;
      logic         dz;
      int           lat;
      md_ref(op, a, b, h, l, dz);
      @(negedge clk);
      md_start = 1'b1; md_op = op; In1 = a; In2 = b; md_flush = (mode == 3);
      @(negedge clk);
      md_start = 1'b0; md_flush = 1'b0; In1 = $urandom; In2 = $urandom;
      check({tag, ".busy"}, 64'(busy), 64'd1);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (mode == 1 && k == 5) begin md_start = 1'b1; md_op = 3'd3; end
         if (mode == 1 && k == 6) md_start = 1'b0;
         if (mode == 2 && k == 10) md_flush = 1'b1;
         if (mode == 2 && k == 11) begin
            md_flush = 1'b0;
            check({tag, ".flush_busy"}, 64'(busy), 64'd0);
         end
         if (done && lat == 0) begin
            lat = k;
            if (mode != 2) break;
         end
      end
      if (mode == 2) begin
         check({tag, ".no_done"}, 64'(lat), 64'd0);
      end else begin
         check({tag, ".latency"}, 64'(lat), 64'(W + 1));
         check({tag, ".div_zero"}, 64'(div_zero), 64'(dz));
         exp_hi = h;
         exp_lo = l;
      end
      check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
      check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
      @(negedge clk);
      check({tag, ".done_pulse"}, 64'(done), 64'd0);
   endtask

   logic [W-1:0] ra, rb;
   logic [3:0]   rop;

   initial begin
      rst_n = 1'b0; md_start = 1'b0; md_flush = 1'b0; md_op = 3'd0;
      In1 = 0; In2 = 0; OP = 4'd0;
      exp_hi = 0; exp_lo = 0;
      #12;
      check("rst.hi", 64'(hi), 64'd0);
      check("rst.lo", 64'(lo), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.div_zero", 64'(div_zero), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      OP = 4'd1; In1 = 5; In2 = 5; #1;
      check("alu.sub", 64'(result), 64'd0);
      check("alu.sub_zero", 64'(Zero_Flag), 64'd1);
      OP = 4'd10; In1 = 4; In2 = 32'h8000_0000; #1;
      check("alu.sra", 64'(result), 64'hF800_0000);
      OP = 4'd7; In1 = 1; In2 = 32'hFFFF_FFFF; #1;
      check("alu.sltu", 64'(result), 64'd1);
      OP = 4'd6; #1;
      check("alu.slt", 64'(result), 64'd0);
      for (int i = 0; i < 24; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = (i % 5 == 0) ? ra : $urandom;
         OP = rop; In1 = ra; In2 = rb; #1;
         check("alu.rand", 64'(result), 64'(alu_ref(rop, ra, rb)));
         check("alu.rand_zero", 64'(Zero_Flag), 64'(alu_ref(rop, ra, rb) == 0));
      end

      run_md("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 0);
      check("mult_neg.const_lo", 64'(lo), 64'hFFFF_FFEB);
      run_md("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check("multu_max.const_hi", 64'(hi), 64'hFFFF_FFFE);
      run_md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
      run_md("divu", 3'd3, 32'd7, 32'd2, 0);
      run_md("div_min", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_md("div_zero", 3'd2, 32'd9, 32'd0, 0);
      run_md("div_negzero", 3'd2, 32'hFFFF_FF00, 32'd0, 0);
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (i[0] ? 32'($urandom_range(1, 300)) : $urandom);
         run_md("md_rand", 3'($urandom_range(0, 3)), ra, rb, 0);
      end

      @(negedge clk);
      md_start = 1'b1; md_op = 3'd4; In1 = 32'h1234;
      @(negedge clk);
      md_start = 1'b0;
      check("mthi.hi", 64'(hi), 64'h1234);
      check("mthi.busy", 64'(busy), 64'd0);
      check("mthi.done", 64'(done), 64'd0);
      exp_hi = 32'h1234;
      ra = $urandom;
      md_start = 1'b1; md_op = 3'd5; In1 = ra;
      @(negedge clk);
      md_start = 1'b0;
      check("mtlo.lo", 64'(lo), 64'(ra));
      check("mtlo.hi", 64'(hi), 64'(exp_hi));
      exp_lo = ra;
      md_start = 1'b1; md_op = 3'd6; In1 = $urandom;
      @(negedge clk);
      md_start = 1'b0;
      check("noop.busy", 64'(busy), 64'd0);
      check("noop.hi", 64'(hi), 64'(exp_hi));
      check("noop.lo", 64'(lo), 64'(exp_lo));

      @(negedge clk);
      md_flush = 1'b1;
      @(negedge clk);
      md_flush = 1'b0;
      check("idle_flush.hi", 64'(hi), 64'(exp_hi));

      run_md("stray_start", 3'd0, $urandom, $urandom, 1);
      run_md("flush", 3'd1, $urandom, $urandom, 2);
      run_md("flush_start", 3'd3, $urandom, 32'd13, 3);

      @(negedge clk);
      md_start = 1'b1; md_op = 3'd2; In1 = 32'd1000; In2 = 32'hFFFF_FFFD;
      @(negedge clk);
      md_start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst.hi", 64'(hi), 64'd0);
      check("async_rst.lo", 64'(lo), 64'd0);
      check("async_rst.busy", 64'(busy), 64'd0);
      check("async_rst.done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_hi = 0;
      exp_lo = 0;
      run_md("post_rst_mult", 3'd0, $urandom, $urandom, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
